// File: rtl/instruments_axil_slave.sv
// AXI4-Lite responder holding four 32-bit instrument registers with byte strobes,
// exported register contents and per-register write pulses.
`timescale 1ns/1ps
module instruments_axil_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [4*C_S_AXI_DATA_WIDTH-1:0] reg_out,
  output logic [3:0]                      wr_pulse
);

  localparam int unsigned DATA_W   = C_S_AXI_DATA_WIDTH;
  localparam int unsigned STRB_W   = DATA_W / 8;
  localparam int unsigned NUM_REGS = 4;
  localparam int unsigned SEL_W    = 2;

  typedef enum logic {RD_IDLE, RD_RESP} rd_state_t;

  logic [DATA_W-1:0]   regs [NUM_REGS];

  logic                aw_held, w_held;
  logic [SEL_W-1:0]    aw_sel;
  logic [DATA_W-1:0]   w_data;
  logic [STRB_W-1:0]   w_strb;
  logic                awready_q, wready_q, bvalid_q;
  logic [NUM_REGS-1:0] wr_pulse_q;

  logic                aw_hs_c, w_hs_c, commit_c;
  logic                aw_held_nxt_c, w_held_nxt_c;
  logic [SEL_W-1:0]    sel_c;
  logic [DATA_W-1:0]   wdata_c;
  logic [STRB_W-1:0]   strb_c;

  rd_state_t           rd_state, rd_state_nxt;
  logic                arready_q, rvalid_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                arready_nxt_c, rvalid_nxt_c;
  logic [DATA_W-1:0]   rdata_nxt_c;

  // Protection bits and sub-word address bits carry no meaning here.
  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // Write commit decision: address and data each come from a holding or a live handshake.
  always_comb begin
    aw_hs_c       = S_AXI_AWVALID & awready_q;
    w_hs_c        = S_AXI_WVALID & wready_q;
    commit_c      = (aw_held | aw_hs_c) & (w_held | w_hs_c) & ~bvalid_q;
    sel_c         = aw_held ? aw_sel : S_AXI_AWADDR[3:2];
    wdata_c       = w_held ? w_data : S_AXI_WDATA;
    strb_c        = w_held ? w_strb : S_AXI_WSTRB;
    aw_held_nxt_c = commit_c ? 1'b0 : (aw_held | aw_hs_c);
    w_held_nxt_c  = commit_c ? 1'b0 : (w_held | w_hs_c);
  end

  // Write-channel holdings, ready flags, response and pulse.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      aw_held    <= 1'b0;
      w_held     <= 1'b0;
      aw_sel     <= '0;
      w_data     <= '0;
      w_strb     <= '0;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      wr_pulse_q <= '0;
    end else begin
      aw_held   <= aw_held_nxt_c;
      w_held    <= w_held_nxt_c;
      awready_q <= ~aw_held_nxt_c;
      wready_q  <= ~w_held_nxt_c;
      if (aw_hs_c && !commit_c) aw_sel <= S_AXI_AWADDR[3:2];
      if (w_hs_c && !commit_c) begin
        w_data <= S_AXI_WDATA;
        w_strb <= S_AXI_WSTRB;
      end
      if (commit_c)          bvalid_q <= 1'b1;
      else if (S_AXI_BREADY) bvalid_q <= 1'b0;
      wr_pulse_q <= commit_c ? (NUM_REGS'(1) << sel_c) : '0;
    end
  end

  // Register file with byte-lane merge on commit.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int unsigned r = 0; r < NUM_REGS; r++) regs[r] <= '0;
    end else if (commit_c) begin
      for (int unsigned b = 0; b < STRB_W; b++) begin
        if (strb_c[b]) regs[sel_c][8*b +: 8] <= wdata_c[8*b +: 8];
      end
    end
  end

  // Read FSM state and registered read outputs.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rd_state  <= RD_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      rd_state  <= rd_state_nxt;
      arready_q <= arready_nxt_c;
      rvalid_q  <= rvalid_nxt_c;
      rdata_q   <= rdata_nxt_c;
    end
  end

  // Read FSM next state; RDATA samples the pre-edge register value on AR handshake.
  always_comb begin
    rd_state_nxt = rd_state;
    rdata_nxt_c  = rdata_q;
    case (rd_state)
      RD_IDLE: begin
        if (S_AXI_ARVALID && arready_q) begin
          rd_state_nxt = RD_RESP;
          rdata_nxt_c  = regs[S_AXI_ARADDR[3:2]];
        end
      end
      RD_RESP: begin
        if (S_AXI_RREADY) rd_state_nxt = RD_IDLE;
      end
      default: rd_state_nxt = RD_IDLE;
    endcase
    arready_nxt_c = (rd_state_nxt == RD_IDLE);
    rvalid_nxt_c  = (rd_state_nxt == RD_RESP);
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = 2'b00;
  assign S_AXI_RVALID  = rvalid_q;
  assign reg_out       = {regs[3], regs[2], regs[1], regs[0]};
  assign wr_pulse      = wr_pulse_q;

endmodule

// File: tb/tb_instruments_axil_slave.sv
// Directed testbench for instruments_axil_slave.
`timescale 1ns/1ps
module tb_instruments_axil_slave;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [3:0]   awaddr = '0;
  logic [2:0]   awprot = '0;
  logic         awvalid = 1'b0;
  logic         awready;
  logic [31:0]  wdata = '0;
  logic [3:0]   wstrb = '0;
  logic         wvalid = 1'b0;
  logic         wready;
  logic [1:0]   bresp;
  logic         bvalid;
  logic         bready = 1'b1;
  logic [3:0]   araddr = '0;
  logic [2:0]   arprot = '0;
  logic         arvalid = 1'b0;
  logic         arready;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rvalid;
  logic         rready = 1'b1;
  logic [127:0] reg_out;
  logic [3:0]   wr_pulse;

  int checks = 0;
  int passed = 0;

  localparam int BUDGET = 50;

  always #5 clk = ~clk;

  instruments_axil_slave dut (
    .ACLK(clk), .ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .reg_out(reg_out), .wr_pulse(wr_pulse)
  );

  // AW+W together, BREADY high; returns response, pulse seen with BVALID, and completion flag.
  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           output logic [1:0] resp, output logic [3:0] pulse, output bit ok);
    bit aw_done = 0, w_done = 0, aw_hs, w_hs;
    int n = 0;
    @(negedge clk);
    awaddr = addr; awvalid = 1'b1; wdata = data; wstrb = strb; wvalid = 1'b1; bready = 1'b1;
    while (!(aw_done && w_done) && n < BUDGET) begin
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      @(negedge clk); n++;
      if (aw_hs) begin aw_done = 1; awvalid = 1'b0; end
      if (w_hs)  begin w_done = 1;  wvalid = 1'b0; end
    end
    while (!bvalid && n < BUDGET) begin @(negedge clk); n++; end
    resp  = bresp;
    pulse = wr_pulse;
    ok    = (n < BUDGET);
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk);
  endtask

  // Single read with RREADY high.
  task automatic axi_read(input logic [3:0] addr, output logic [31:0] data,
                          output logic [1:0] resp, output bit ok);
    bit hs;
    int n = 0;
    @(negedge clk);
    araddr = addr; arvalid = 1'b1; rready = 1'b1;
    hs = 0;
    while (!hs && n < BUDGET) begin
      hs = arvalid && arready;
      @(negedge clk); n++;
    end
    arvalid = 1'b0;
    while (!rvalid && n < BUDGET) begin @(negedge clk); n++; end
    data = rdata;
    resp = rresp;
    ok   = (n < BUDGET);
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] d; logic [1:0] r; bit ok;
    rst_n = 1'b0;
    #200;
    checks++;
    if ({awready, wready, arready, bvalid, rvalid} !== 5'b0)
      $display("FAIL reset_handshake_flags got=%b exp=00000", {awready, wready, arready, bvalid, rvalid});
    else passed++;
    checks++;
    if ({rdata, reg_out, wr_pulse} !== '0)
      $display("FAIL reset_data got rdata=%h reg_out=%h wr_pulse=%b exp=0", rdata, reg_out, wr_pulse);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({awready, wready, arready} !== 3'b111)
      $display("FAIL reset_release_readies got=%b exp=111", {awready, wready, arready});
    else passed++;
    for (int i = 0; i < 4; i++) begin
      axi_read(4'(i * 4), d, r, ok);
      checks++;
      if (!ok || d !== 32'h0 || r !== 2'b00)
        $display("FAIL reset_read_%0d got=%h resp=%b ok=%0d exp=00000000", i, d, r, ok);
      else passed++;
    end
  endtask

  task automatic test_seq_write_read();
    logic [31:0] d; logic [1:0] r; logic [3:0] p; bit ok;
    for (int i = 0; i < 4; i++) begin
      axi_write(4'(i * 4), 32'(i + 1), 4'hF, r, p, ok);
      checks++;
      if (!ok || r !== 2'b00 || p !== 4'(1 << i))
        $display("FAIL seq_write_%0d got resp=%b pulse=%b ok=%0d exp resp=00 pulse=%b", i, r, p, ok, 4'(1 << i));
      else passed++;
    end
    checks++;
    if (reg_out !== {32'h4, 32'h3, 32'h2, 32'h1})
      $display("FAIL seq_reg_out got=%h exp=%h", reg_out, {32'h4, 32'h3, 32'h2, 32'h1});
    else passed++;
    for (int i = 0; i < 4; i++) begin
      axi_read(4'(i * 4), d, r, ok);
      checks++;
      if (!ok || d !== 32'(i + 1) || r !== 2'b00)
        $display("FAIL seq_read_%0d got=%h resp=%b exp=%h", i, d, r, 32'(i + 1));
      else passed++;
    end
  endtask

  task automatic test_w_before_aw();
    @(negedge clk);
    bready = 1'b1;
    wdata = 32'hCAFE0008; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clk);
    wvalid = 1'b0;
    checks++;
    if (wready !== 1'b0 || awready !== 1'b1)
      $display("FAIL w_first_wready got wready=%b awready=%b exp 0/1", wready, awready);
    else passed++;
    repeat (2) @(negedge clk);
    checks++;
    if (wready !== 1'b0 || bvalid !== 1'b0 || reg_out[95:64] !== 32'h3)
      $display("FAIL w_first_wait got wready=%b bvalid=%b reg2=%h exp 0/0/00000003", wready, bvalid, reg_out[95:64]);
    else passed++;
    awaddr = 4'h8; awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    checks++;
    if (bvalid !== 1'b1 || wr_pulse !== 4'b0100 || reg_out[95:64] !== 32'hCAFE0008)
      $display("FAIL w_first_commit got bvalid=%b pulse=%b reg2=%h exp 1/0100/cafe0008", bvalid, wr_pulse, reg_out[95:64]);
    else passed++;
    checks++;
    if ({awready, wready} !== 2'b11)
      $display("FAIL w_first_readies got=%b exp=11", {awready, wready});
    else passed++;
    @(negedge clk);
    checks++;
    if (bvalid !== 1'b0 || wr_pulse !== 4'b0000)
      $display("FAIL w_first_bdone got bvalid=%b pulse=%b exp 0/0000", bvalid, wr_pulse);
    else passed++;
  endtask

  task automatic test_b_backpressure();
    bit bad;
    @(negedge clk);
    bready = 1'b0;
    awaddr = 4'h0; awvalid = 1'b1; wdata = 32'h11111111; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clk);
    checks++;
    if (bvalid !== 1'b1 || wr_pulse !== 4'b0001)
      $display("FAIL bp_first_commit got bvalid=%b pulse=%b exp 1/0001", bvalid, wr_pulse);
    else passed++;
    awaddr = 4'h4; wdata = 32'h22222222;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    checks++;
    if ({awready, wready} !== 2'b00)
      $display("FAIL bp_second_captured got readies=%b exp=00", {awready, wready});
    else passed++;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (bvalid !== 1'b1 || reg_out[63:32] !== 32'h2 || wr_pulse !== 4'b0) bad = 1;
      @(negedge clk);
    end
    checks++;
    if (bad || bvalid !== 1'b1)
      $display("FAIL bp_hold got bvalid=%b reg1=%h exp bvalid=1 reg1=00000002 throughout", bvalid, reg_out[63:32]);
    else passed++;
    bready = 1'b1;
    @(negedge clk);
    checks++;
    if (bvalid !== 1'b0 || reg_out[63:32] !== 32'h2)
      $display("FAIL bp_release got bvalid=%b reg1=%h exp 0/00000002", bvalid, reg_out[63:32]);
    else passed++;
    @(negedge clk);
    checks++;
    if (bvalid !== 1'b1 || wr_pulse !== 4'b0010 || reg_out[63:32] !== 32'h22222222)
      $display("FAIL bp_second_commit got bvalid=%b pulse=%b reg1=%h exp 1/0010/22222222", bvalid, wr_pulse, reg_out[63:32]);
    else passed++;
    @(negedge clk);
  endtask

  task automatic test_strobes();
    logic [31:0] d; logic [1:0] r; logic [3:0] p; bit ok1, ok2, ok3;
    axi_write(4'h4, 32'hFFFFFFFF, 4'hF, r, p, ok1);
    axi_write(4'h4, 32'h12345678, 4'b0101, r, p, ok2);
    axi_read(4'h4, d, r, ok3);
    checks++;
    if (!ok1 || !ok2 || !ok3 || d !== 32'hFF34FF78)
      $display("FAIL strobe_merge got=%h exp=ff34ff78", d);
    else passed++;
    axi_read(4'h5, d, r, ok3);
    checks++;
    if (!ok3 || d !== 32'hFF34FF78 || r !== 2'b00)
      $display("FAIL strobe_alias_read got=%h resp=%b exp=ff34ff78/00", d, r);
    else passed++;
  endtask

  task automatic test_collision();
    logic [31:0] d; logic [1:0] r; bit ok;
    @(negedge clk);
    bready = 1'b1; rready = 1'b0;
    awaddr = 4'hC; awvalid = 1'b1; wdata = 32'hAAAA5555; wstrb = 4'hF; wvalid = 1'b1;
    araddr = 4'hC; arvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    checks++;
    if (rvalid !== 1'b1 || rdata !== 32'h4)
      $display("FAIL collide_old_value got rvalid=%b rdata=%h exp 1/00000004", rvalid, rdata);
    else passed++;
    checks++;
    if (bvalid !== 1'b1 || reg_out[127:96] !== 32'hAAAA5555)
      $display("FAIL collide_commit got bvalid=%b reg3=%h exp 1/aaaa5555", bvalid, reg_out[127:96]);
    else passed++;
    @(negedge clk);
    checks++;
    if (rvalid !== 1'b1 || rdata !== 32'h4)
      $display("FAIL collide_rdata_stable got rvalid=%b rdata=%h exp 1/00000004", rvalid, rdata);
    else passed++;
    rready = 1'b1;
    @(negedge clk);
    axi_read(4'hC, d, r, ok);
    checks++;
    if (!ok || d !== 32'hAAAA5555)
      $display("FAIL collide_new_value got=%h exp=aaaa5555", d);
    else passed++;
  endtask

  task automatic test_mid_reset();
    logic [31:0] d; logic [1:0] r; bit ok;
    @(negedge clk);
    rready = 1'b0; araddr = 4'h0; arvalid = 1'b1;
    @(negedge clk);
    arvalid = 1'b0;
    checks++;
    if (rvalid !== 1'b1 || rdata !== 32'h11111111)
      $display("FAIL midrst_pending got rvalid=%b rdata=%h exp 1/11111111", rvalid, rdata);
    else passed++;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (rvalid !== 1'b0 || arready !== 1'b0 || reg_out !== '0 || rdata !== '0)
      $display("FAIL midrst_async got rvalid=%b arready=%b reg_out=%h rdata=%h exp all 0", rvalid, arready, reg_out, rdata);
    else passed++;
    @(negedge clk);
    rready = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      axi_read(4'(i * 4), d, r, ok);
      checks++;
      if (!ok || d !== 32'h0)
        $display("FAIL midrst_read_%0d got=%h exp=00000000", i, d);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_seq_write_read();
    test_w_before_aw();
    test_b_backpressure();
    test_strobes();
    test_collision();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/instruments_axil_slave.md
# instruments_axil_slave

AXI4-Lite responder register file for the instruments IP. It terminates the S00_AXI port that the instruments master VIP drives, and holds four 32-bit software-visible registers at offsets 0x0, 0x4, 0x8 and 0xC. Register contents and per-register write strobes are exported to the instrument logic. AW, W, B, AR and R handshakes follow AXI4-Lite with full backpressure support.

## Interface
- C_S_AXI_DATA_WIDTH, 32, data width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 4, address width; bits [3:2] select the register and all other bits are ignored.
- ACLK  in  1  single clock; all logic uses the rising edge.
- ARESETN  in  1  reset, asynchronous, active-low.
- S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  write address handshake.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte enables.
- S_AXI_WVALID / S_AXI_WREADY  in / out  1  write data handshake.
- S_AXI_BRESP  out  2  always 2'b00 (OKAY).
- S_AXI_BVALID / S_AXI_BREADY  out / in  1  write response handshake.
- S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  read address handshake.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  always 2'b00.
- S_AXI_RVALID / S_AXI_RREADY  out / in  1  read data handshake.
- reg_out  out  128  register contents; reg N is bits [32N+31:32N].
- wr_pulse  out  4  one-cycle pulse on bit N in the cycle after register N is written.

## Operation
- **Write address holding.** aw_held holds the captured AWADDR[3:2].
- **Write data holding.** w_held holds the captured WDATA and WSTRB.
- **Independent acceptance.** AW and W are accepted independently, in either order or in the same cycle.
- **Ready rule.** AWREADY is registered and equals ~aw_held after each edge. WREADY is registered and equals ~w_held after each edge.
- **Write commit condition.** A commit happens at an edge where all of the following are true:
  - an address is available, either held or handshaking at that edge;
  - data is available, either held or handshaking at that edge;
  - BVALID is 0 before the edge.
- **Write commit effects.**
  - Each byte b of the selected register with WSTRB[b]=1 takes WDATA[8b+7:8b]; bytes with WSTRB[b]=0 keep their value.
  - Both holdings clear.
  - BVALID is set to 1.
  - wr_pulse[sel] is 1 for exactly one cycle.
- **Write response.** BVALID clears at the edge where BREADY=1. While BVALID=1, no further commit occurs; new AW/W may still be captured into empty holdings.
- **Read channel states.** IDLE (ARREADY=1, RVALID=0) and RESP (ARREADY=0, RVALID=1).
- **Read transitions.**
  - IDLE->RESP on an AR handshake. RDATA is loaded with the register selected by ARADDR[3:2], using its value before the edge.
  - RESP->IDLE at the edge where RREADY=1.
- **RDATA stability.** RDATA holds stable while RVALID=1.
- **Simultaneous read and commit to the same register.** The read returns the old value; the register takes the new value.
- **Unmapped offsets.** Address bits above [3:2] alias onto the four registers; the response is always OKAY.

## Timing
- **During reset (ARESETN=0, asynchronous).**
  - AWREADY, WREADY, ARREADY, BVALID and RVALID are 0.
  - RDATA, all registers, reg_out and wr_pulse are 0.
  - Holdings are empty.
- **Reset release.** AWREADY, WREADY and ARREADY rise at the first rising edge after ARESETN returns high.
- **Reset mid-transaction.** Outstanding captured AW/W and pending B/R are discarded with no response.
- **Write latency.** BVALID is high one cycle after the commit edge. The best case is AW+W together, giving BVALID the cycle after the handshake.
- **Write throughput.** With BREADY tied 1, the peak rate is one write per 2 cycles.
- **Read latency.** RVALID and RDATA are valid the cycle after the AR handshake.
- **Read throughput.** With RREADY tied 1, the peak rate is one read per 2 cycles.
- **Output timing.** reg_out updates in the cycle after commit; wr_pulse is aligned with it.
- **No combinational paths.** No output depends combinationally on any input.

## Test plan
- **Reset values.** Hold ARESETN low for 200 ns, then release -> all outputs are 0 during reset; the three READYs are 1 after the first edge; reads of all offsets return 0.
- **Sequential write/readback.** Write 0x1, 0x2, 0x3, 0x4 to 0x0, 0x4, 0x8, 0xC, then read them back -> each BRESP is OKAY; RDATA is 0x1, 0x2, 0x3, 0x4; wr_pulse shows bits 0..3 pulsing in order.
- **Channel ordering and backpressure.**
  - W before AW, with W presented 3 cycles early to 0x8 -> WREADY drops after the W handshake; commit happens on the AW handshake.
  - BREADY held low for 5 cycles -> BVALID stays high and a second AW+W is captured but not committed until BREADY=1.
- **Byte strobes.** Write 0xFFFFFFFF to 0x4, then write 0x12345678 with WSTRB=4'b0101 -> read of 0x4 returns 0xFF34FF78.
- **Read/write collision.** In the same cycle, AR to 0xC and a commit of 0xAAAA5555 to 0xC, with old value 0x4 -> RDATA is 0x4; the next read returns 0xAAAA5555.
- **Mid-operation reset.** Assert ARESETN low while RVALID=1 with RREADY low -> RVALID drops immediately without waiting for a clock; all registers read 0 afterwards.
